// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative signed/unsigned divider for the execute stage.
// Produces {remainder, quotient} for DIV/DIVU with one quotient bit per cycle
// (restoring radix-2, MSB first), and raises the stall request consumed by the
// hazard unit while the operation is in flight.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset (overrides flush and start)
//   start        - E-stage instruction is DIV/DIVU (level)
//   signed_div   - 1 = DIV, 0 = DIVU; sampled with start
//   opa, opb     - dividend / divisor; sampled with start
//   flush        - exception flush; aborts any operation
//   hold         - data-cache freeze; only extends the DONE state
//   div_stall    - stall request to the hazard unit
//   result_valid - result is final this cycle
//   result       - {remainder, quotient}, registered
module div_iter_unit #(
  parameter int unsigned WIDTH = 32  // must be >= 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               flush,
  input  logic               hold,
  output logic               div_stall,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  rem_q;      // partial remainder
  logic [WIDTH-1:0]  quo_q;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]  dvsr_q;
  logic [WIDTH-1:0]  opa_raw_q;  // remainder for divide-by-zero
  logic              q_neg_q;
  logic              r_neg_q;
  logic              dbz_q;
  logic [2*WIDTH-1:0] result_q;

  // Operand capture: magnitudes only for signed divides. The most negative
  // value negates to itself, which yields the expected overflow result.
  logic             opa_neg, opb_neg;
  logic [WIDTH-1:0] opa_abs, opb_abs;

  assign opa_neg = signed_div & opa[WIDTH-1];
  assign opb_neg = signed_div & opb[WIDTH-1];
  assign opa_abs = opa_neg ? (~opa + One) : opa;
  assign opb_abs = opb_neg ? (~opb + One) : opb;

  // One restoring step on {rem, dividend}.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next, quo_next, q_final, r_final;

  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = {1'b0, shifted} - {2'b00, dvsr_q};
  assign fits     = ~diff[WIDTH+1];
  // When the subtraction succeeds the difference is below the divisor, so the
  // top bit is always zero; otherwise shifted is below the divisor.
  assign rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo_q[WIDTH-2:0], fits};

  assign q_final = dbz_q ? '1 : (q_neg_q ? (~quo_next + One) : quo_next);
  assign r_final = dbz_q ? opa_raw_q : (r_neg_q ? (~rem_next + One) : rem_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      opa_raw_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            rem_q     <= '0;
            quo_q     <= opa_abs;
            dvsr_q    <= opb_abs;
            opa_raw_q <= opa;
            q_neg_q   <= opa_neg ^ opb_neg;
            r_neg_q   <= opa_neg;
            dbz_q     <= (opb == '0);
            cnt_q     <= '0;
            state_q   <= StBusy;
          end
        end
        StBusy: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q + CntOne;
          if (cnt_q == LastCnt) begin
            result_q <= {r_final, q_final};
            state_q  <= StDone;
          end
        end
        StDone: begin
          // start is ignored here so the held instruction is not re-executed
          if (!hold) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall must rise in the same cycle the DIV reaches E, hence combinational.
  always_comb begin
    div_stall    = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      StIdle:  div_stall    = start & ~flush;
      StBusy:  div_stall    = ~flush;
      StDone:  result_valid = ~flush;
      default: ;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed vector table, hand-written
// multi-cycle sequences (hold, flush, reset) and randomized operands checked
// against an arithmetic reference model.
module tb_div_iter_unit;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst, start, signed_div, flush, hold;
  logic [W-1:0]  opa, opb;
  logic          div_stall, result_valid;
  logic [2*W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .opa          (opa),
    .opb          (opb),
    .flush        (flush),
    .hold         (hold),
    .div_stall    (div_stall),
    .result_valid (result_valid),
    .result       (result)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic from the architectural rules.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end
    return {r, q};
  endfunction

  // Entered and left at posedge+1. Runs one divide, checks the 33-cycle stall,
  // the result, and hold_n extra DONE cycles with start still high.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int hold_n, input logic [63:0] exp, input string name);
    int stalls;
    bit done;
    stalls     = 0;
    done       = 1'b0;
    start      = 1'b1;
    signed_div = sgn;
    opa        = a;
    opb        = b;
    hold       = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (result_valid) begin
        done = 1'b1;
      end else begin
        if (div_stall) stalls++;
        @(posedge clk);
        #1;
      end
    end
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " stall"}, 64'(stalls), 64'd33);
    check({name, " result"}, result, exp);
    for (int h = 0; h < hold_n; h++) begin
      hold = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check({name, " hold valid"}, 64'(result_valid), 64'd1);
      check({name, " hold result"}, result, exp);
    end
    hold = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_check(input string name, input logic [63:0] exp);
    @(negedge clk);
    check({name, " idle stall"}, 64'(div_stall), 64'd0);
    check({name, " idle valid"}, 64'(result_valid), 64'd0);
    check({name, " idle result"}, result, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    bit          seen;

    tbl[0]  = '{32'd100,        32'd7,          1'b0, {32'h0000_0002, 32'h0000_000E}};
    tbl[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    tbl[2]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0000_0000, 32'h8000_0000}};
    tbl[3]  = '{32'h1234_5678,  32'd0,          1'b0, {32'h1234_5678, 32'hFFFF_FFFF}};
    tbl[4]  = '{32'h1234_5678,  32'd0,          1'b1, {32'h1234_5678, 32'hFFFF_FFFF}};
    tbl[5]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, {32'h0000_0001, 32'h7FFF_FFFC}};
    tbl[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'h0000_0000}};
    tbl[7]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, {32'h0000_0001, 32'hFFFF_FFFD}};
    tbl[8]  = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, {32'hFFFF_FFFE, 32'h0000_000E}};
    tbl[9]  = '{32'd9,          32'd3,          1'b0, {32'h0000_0000, 32'h0000_0003}};
    tbl[10] = '{32'd5,          32'd9,          1'b0, {32'h0000_0005, 32'h0000_0000}};
    tbl[11] = '{32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0000_0000, 32'hFFFF_FFFF}};
    tbl[12] = '{32'h8000_0000,  32'd0,          1'b1, {32'h8000_0000, 32'hFFFF_FFFF}};

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    flush = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    idle_check("reset", 64'd0);

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_div(tbl[i].a, tbl[i].b, tbl[i].sgn, 0, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    idle_check("after table", tbl[12].exp);

    // Hold for 3 cycles in DONE, then a back-to-back DIV
    do_div(32'd100, 32'd7, 1'b0, 3, {32'h2, 32'hE}, "hold3");
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "b2b");
    idle_check("after b2b", {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Flush at BUSY cycle 10, then a fresh 9/3 with full latency
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush busy stall", 64'(div_stall), 64'd0);
    check("flush busy valid", 64'(result_valid), 64'd0);
    check("flush busy result", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(posedge clk);
    #1;
    flush = 1'b0;
    do_div(32'd9, 32'd3, 1'b0, 0, {32'h0, 32'h3}, "after flush");

    // Flush in IDLE with start high must not launch an operation
    start = 1'b1; opa = 32'd50; opb = 32'd5; flush = 1'b1;
    @(negedge clk);
    check("flush idle stall", 64'(div_stall), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    idle_check("flush idle next", {32'h0, 32'h3});

    // Flush while held in DONE
    start = 1'b1; signed_div = 1'b0; opa = 32'd50; opb = 32'd5;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
      hold = 1'b1;
      @(posedge clk);
      #1;
    end
    check("flush done reached", 64'(seen), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    check("flush done valid", 64'(result_valid), 64'd0);
    check("flush done result", result, {32'h0, 32'd10});
    @(posedge clk);
    #1;
    flush = 1'b0; hold = 1'b0; start = 1'b0;
    idle_check("flush done next", {32'h0, 32'd10});

    // Reset at BUSY cycle 5
    start = 1'b1; signed_div = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_check("rst busy", 64'd0);
    idle_check("rst busy next", 64'd0);

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) rb = ~rb + 32'd1;
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, int'($urandom_range(0, 2)), model(ra, rb, rs),
             $sformatf("rand%0d %h/%h s%0d", i, ra, rb, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Iterative 32-bit signed/unsigned divider in the execute stage. It produces the `{remainder, quotient}` pair for DIV/DIVU and drives the stall request that the hazard unit consumes as `alu_stallE`. While it is busy, F/D/E hold and M takes bubbles. It also honours exception flushes and data-cache stalls so that a result is never lost or applied twice.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  the E-stage instruction is DIV/DIVU; level, held high while the instruction sits in E.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `start`.
- `opa`  in  WIDTH  dividend; sampled with `start`.
- `opb`  in  WIDTH  divisor; sampled with `start`.
- `flush`  in  1  exception flush (`flush_exceptionM`); aborts any operation.
- `hold`  in  1  pipeline frozen by the data cache (`d_cache_stall`).
- `div_stall`  out  1  stall request, wired to `alu_stallE`.
- `result_valid`  out  1  `result` is final this cycle.
- `result`  out  2*WIDTH  `{remainder[WIDTH-1:0], quotient[WIDTH-1:0]}` (HI, LO).

## Operation
- States: IDLE, BUSY, DONE. Reset puts the unit in IDLE with counter 0 and `result` 0. After reset, `div_stall` is 0, `result_valid` is 0 and `result` is 0.
- IDLE:
  - `div_stall` = `start & ~flush`, combinational, so the stall is raised in the same cycle the DIV reaches E.
  - When `start & ~flush`: latch |opa| and |opb| (absolute values only when `signed_div` is set), quotient sign = sign(opa) XOR sign(opb), remainder sign = sign(opa), a divide-by-zero flag, and the raw `opa`. Clear the partial remainder. Go to BUSY with counter = 0.
- BUSY:
  - Restoring radix-2, one quotient bit per cycle, MSB first.
  - Each cycle: shift `{rem, dividend}` left by 1, subtract the divisor from the upper (WIDTH+1) bits, keep the difference if it is non-negative, and shift in the quotient bit.
  - `div_stall` = 1.
  - When the counter reaches WIDTH-1, go to DONE.
- DONE:
  - `div_stall` = 0 and `result_valid` = 1.
  - `result` is the sign-corrected quotient and remainder, held in a register.
  - If `~hold`, go to IDLE; the E-stage instruction advances on this same edge. If `hold`, stay in DONE with `result` stable.
  - `start` is ignored in DONE, so the operation is not restarted.
- Divide by zero: quotient = all ones and remainder = `opa` raw, regardless of `signed_div`. Latency is the same as a normal divide.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out naturally from the WIDTH-bit wrap of the negation.
- `flush`: in any state, the next state is IDLE and `div_stall` is forced to 0 in the flush cycle. `result_valid` is 0 in that cycle. `result` is unchanged.
- `rst` overrides `flush` and `start`.

## Timing
- Cycle 0: `start` rises in IDLE and `div_stall` = 1.
- Cycles 1..32: BUSY, `div_stall` = 1.
- Cycle 33: DONE, `div_stall` = 0, `result_valid` = 1.
- Total stall is 33 cycles; result-to-advance takes 34 cycles when `hold` = 0.
- Back-to-back DIVs: the second instruction enters E on the cycle after DONE, and its IDLE cycle starts a new operation. There are no dead cycles beyond the 34.
- `hold` during BUSY has no effect; iteration continues. `hold` only extends DONE.
- `flush` and the DONE-exit in the same cycle resolve to IDLE; the instruction is annulled downstream by the hazard unit.
- `result` updates only on the BUSY→DONE edge.

## Test plan
- Unsigned: `opa`=100, `opb`=7, `signed_div`=0 → `div_stall` high for exactly 33 cycles, then `result` = {0x00000002, 0x0000000E} with `result_valid` for 1 cycle.
- Signed: `opa`=0xFFFFFFF9 (−7), `opb`=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Divide by zero: `opa`=0x12345678, `opb`=0 (both modes) → {0x12345678, 0xFFFFFFFF} after the same 33-cycle stall.
- Flush at BUSY cycle 10 → `div_stall` 0 in that cycle and IDLE next. A fresh `start` with 9/3 then gives {0, 3} after the full latency.
- `hold` high for 3 cycles on entering DONE → `result_valid` and `result` stable for 4 cycles, with no restart. Then IDLE, and a back-to-back DIV begins on the next cycle.
- `rst` asserted at BUSY cycle 5 → next cycle: IDLE, all outputs 0.
